// File: rtl/main_mem_responder_if.sv
// Cache-to-main-memory bundle: write-back and refill request/ack channels.
// Adds the err flag when MAIN_MEM_RANGE_CHECK_EN is defined.
interface main_mem_responder_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic                     wb_valid;
   logic [ADDRESS_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0]    wb_data;
   logic                     wb_ack;
   logic                     rd_valid;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic                     rd_ack;
   logic [DATA_WIDTH-1:0]    rd_data;
   logic                     busy;
`ifdef MAIN_MEM_RANGE_CHECK_EN
   logic                     err;

   modport master (
      output wb_valid, wb_addr, wb_data, rd_valid, rd_addr,
      input  wb_ack, rd_ack, rd_data, busy, err
   );
   modport slave (
      input  wb_valid, wb_addr, wb_data, rd_valid, rd_addr,
      output wb_ack, rd_ack, rd_data, busy, err
   );
`else
   modport master (
      output wb_valid, wb_addr, wb_data, rd_valid, rd_addr,
      input  wb_ack, rd_ack, rd_data, busy
   );
   modport slave (
      input  wb_valid, wb_addr, wb_data, rd_valid, rd_addr,
      output wb_ack, rd_ack, rd_data, busy
   );
`endif
endinterface

// File: rtl/main_mem_responder.sv
// Word-addressed backing store answering write-backs and refills after LATENCY
// cycles. Optional out-of-range flagging: define MAIN_MEM_RANGE_CHECK_EN.
module main_mem_responder #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DEPTH         = 1024,
   parameter int LATENCY       = 4
) (
   input logic                 clk,
   input logic                 reset,
   main_mem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
   typedef enum logic {OP_READ, OP_WRITE} op_e;

   state_e                state_q;
   op_e                   op_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  bad_q;
   logic                  wb_ack_q;
   logic                  rd_ack_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Contents survive reset; only power-up clears them.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

   logic [ADDRESS_WIDTH-1:0] addr_d;
   logic [IDX_W-1:0]         idx_d;
   logic                     bad_d;
   logic                     commit_d;
   logic                     unused_addr;

   assign addr_d      = bus.wb_valid ? bus.wb_addr : bus.rd_addr;
   assign idx_d       = addr_d[IDX_W+1:2];
   assign unused_addr = ^addr_d;

`ifdef MAIN_MEM_RANGE_CHECK_EN
   logic err_q;
   assign bad_d   = |(addr_d >> (IDX_W + 2));
   assign bus.err = err_q;
`else
   assign bad_d   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= OP_READ;
         cnt_q     <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         bad_q     <= 1'b0;
         wb_ack_q  <= 1'b0;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
`ifdef MAIN_MEM_RANGE_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         wb_ack_q <= 1'b0;
         rd_ack_q <= 1'b0;
`ifdef MAIN_MEM_RANGE_CHECK_EN
         err_q    <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               // Write-back has priority; a held read is taken afterwards.
               if (bus.wb_valid || bus.rd_valid) begin
                  op_q    <= bus.wb_valid ? OP_WRITE : OP_READ;
                  idx_q   <= idx_d;
                  data_q  <= bus.wb_data;
                  bad_q   <= bad_d;
                  cnt_q   <= CNT_LOAD;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  state_q <= RESP;
                  if (op_q == OP_WRITE) begin
                     wb_ack_q <= 1'b1;
                  end else begin
                     rd_ack_q  <= 1'b1;
                     rd_data_q <= bad_q ? '1 : mem_q[idx_q];
                  end
`ifdef MAIN_MEM_RANGE_CHECK_EN
                  err_q <= bad_q;
`endif
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign commit_d = (state_q == WAIT) && (cnt_q == '0) &&
                     (op_q == OP_WRITE) && !bad_q && !reset;

   always_ff @(posedge clk) begin
      if (commit_d) begin
         mem_q[idx_q] <= data_q;
      end
   end

   assign bus.wb_ack  = wb_ack_q;
   assign bus.rd_ack  = rd_ack_q;
   assign bus.rd_data = rd_data_q;
   assign bus.busy    = (state_q != IDLE);
endmodule
